decode_stage: RTL

Second pipeline stage of the in-order core, directly downstream of the fetch stage. Decodes the 32-bit instruction and the PC+4 value that fetch delivers each enabled cycle, and reads two operands from the 32×32 architectural register file, which this block owns. It detects load-use hazards against the instruction in execute and registers a decoded bundle into the ID/EX pipeline register. The register-file write port is driven by writeback.

---
 rtl/core_pkg.sv | 66 ++++++
 rtl/decode_stage_if.sv | 46 ++++
 rtl/reg_file.sv | 44 ++++
 rtl/decode_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the in-order core pipeline: datapath sizes,
// instruction opcodes, instruction field positions, ALU operation encoding and
// the ID/EX pipeline register bundle (also imported by execute).
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    // Opcodes (instruction bits [31:25])
    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_MUL  = 7'h02;
    localparam logic [6:0] OP_LDB  = 7'h10;
    localparam logic [6:0] OP_LDW  = 7'h11;
    localparam logic [6:0] OP_STB  = 7'h12;
    localparam logic [6:0] OP_STW  = 7'h13;
    localparam logic [6:0] OP_MOV  = 7'h14;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;

    // Instruction field slices
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 25;
    localparam int RD_HI   = 24;
    localparam int RD_LO   = 20;
    localparam int R1_HI   = 19;
    localparam int R1_LO   = 15;
    localparam int R2_HI   = 14;
    localparam int R2_LO   = 10;
    localparam int IMM_HI  = 14;
    localparam int BOFF_HI = 9;   // low part of the branch offset is [9:0]

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_MUL    = 2'b10,
        ALU_PASS_B = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        alu_op_t           alu_op;
        logic              use_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_byte;
        logic              branch;
        logic              jump;
        logic              illegal;
    } id_ex_t;

    function automatic logic [XLEN-1:0] sext15(input logic [14:0] v);
        return {{(XLEN-15){v[14]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Bundles the fetch->decode inputs, the writeback register-file write port,
// the stall back to fetch and the registered ID/EX outputs.
//   slave  : used by decode_stage (consumes fetch/writeback, drives ID/EX)
//   master : used by the surrounding pipeline / testbench
// -----------------------------------------------------------------------------
interface decode_stage_if;
    import core_pkg::*;

    logic [XLEN-1:0]   instruction;
    logic [XLEN-1:0]   PCnext;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              stall_fetch;
    logic [XLEN-1:0]   pc_out;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd_out;
    logic [1:0]        alu_op;
    logic              use_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_byte;
    logic              branch;
    logic              jump;
    logic              illegal;

    modport slave (
        input  instruction, PCnext, wb_en, wb_addr, wb_data,
        output stall_fetch, pc_out, op_a, op_b, imm, rd_out, alu_op,
               use_imm, reg_write, mem_read, mem_write, mem_byte,
               branch, jump, illegal
    );

    modport master (
        output instruction, PCnext, wb_en, wb_addr, wb_data,
        input  stall_fetch, pc_out, op_a, op_b, imm, rd_out, alu_op,
               use_imm, reg_write, mem_read, mem_write, mem_byte,
               branch, jump, illegal
    );

endinterface

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32x32 architectural register file: two combinational read ports, one
// synchronous write port. r0 always reads zero and ignores writes. A write in
// the same cycle as a read of the same (nonzero) register is bypassed so the
// reader sees the new value.
// Ports: clk, reset (sync, clears all registers), we/waddr/wdata (write),
//        raddr_a/rdata_a, raddr_b/rdata_b (reads).
// -----------------------------------------------------------------------------
module reg_file
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_ok;

    assign wr_ok = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0)               ? '0    :
                     (wr_ok && waddr == raddr_a)   ? wdata : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0)               ? '0    :
                     (wr_ok && waddr == raddr_b)   ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Second pipeline stage. Decodes the instruction from fetch, reads operands
// from the owned register file, detects load-use hazards against the
// instruction currently in execute, and registers the decoded bundle into the
// ID/EX pipeline register.
// Ports: clk, reset (sync active-high), flush (squash ID/EX only),
//        EN_REG (pipeline advance enable), bus (decode_stage_if.slave).
// -----------------------------------------------------------------------------
module decode_stage
    import core_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           EN_REG,
    decode_stage_if.slave  bus
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] f_rd, f_r1, f_r2, rb_addr;
    logic [14:0]       f_imm15, f_boff;
    logic              is_store;
    logic [XLEN-1:0]   rs_a, rs_b;
    logic              use_a, use_b;
    logic              stall_fetch;
    id_ex_t            dec;
    id_ex_t            id_ex_d, id_ex_q;

    assign opcode   = bus.instruction[OPC_HI:OPC_LO];
    assign f_rd     = bus.instruction[RD_HI:RD_LO];
    assign f_r1     = bus.instruction[R1_HI:R1_LO];
    assign f_r2     = bus.instruction[R2_HI:R2_LO];
    assign f_imm15  = bus.instruction[IMM_HI:0];
    assign f_boff   = {bus.instruction[RD_HI:RD_LO], bus.instruction[BOFF_HI:0]};
    assign is_store = (opcode == OP_STB) || (opcode == OP_STW);
    // Stores read the data register through the second port (rd field).
    assign rb_addr  = is_store ? f_rd : f_r2;

    reg_file u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.wb_en),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (f_r1),
        .raddr_b (rb_addr),
        .rdata_a (rs_a),
        .rdata_b (rs_b)
    );

    always_comb begin
        dec    = '0;
        use_a  = 1'b0;
        use_b  = 1'b0;
        dec.pc = bus.PCnext;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL: begin
                dec.op_a      = rs_a;
                dec.op_b      = rs_b;
                dec.rd        = f_rd;
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_op_t'(opcode[1:0]);
                use_a         = 1'b1;
                use_b         = 1'b1;
            end
            OP_LDB, OP_LDW: begin
                dec.op_a      = rs_a;
                dec.imm       = sext15(f_imm15);
                dec.rd        = f_rd;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.use_imm   = 1'b1;
                dec.mem_byte  = (opcode == OP_LDB);
                use_a         = 1'b1;
            end
            OP_STB, OP_STW: begin
                dec.op_a      = rs_a;
                dec.op_b      = rs_b;
                dec.imm       = sext15(f_imm15);
                dec.mem_write = 1'b1;
                dec.use_imm   = 1'b1;
                dec.mem_byte  = (opcode == OP_STB);
                use_a         = 1'b1;
                use_b         = 1'b1;
            end
            OP_MOV: begin
                dec.imm       = sext15(f_imm15);
                dec.rd        = f_rd;
                dec.reg_write = 1'b1;
                dec.use_imm   = 1'b1;
                dec.alu_op    = ALU_PASS_B;
            end
            OP_BEQ: begin
                dec.op_a      = rs_a;
                dec.op_b      = rs_b;
                dec.imm       = sext15(f_boff);
                dec.branch    = 1'b1;
                dec.alu_op    = ALU_SUB;
                use_a         = 1'b1;
                use_b         = 1'b1;
            end
            OP_JUMP: begin
                dec.op_a      = rs_a;
                dec.imm       = sext15(f_imm15);
                dec.jump      = 1'b1;
                dec.use_imm   = 1'b1;
                use_a         = 1'b1;
            end
            default: begin
                dec         = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Load-use: the load in execute targets a register this instruction reads.
    assign stall_fetch = id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                         ((use_a && (f_r1 == id_ex_q.rd)) ||
                          (use_b && (rb_addr == id_ex_q.rd)));

    always_comb begin
        id_ex_d = id_ex_q;
        if (flush) begin
            id_ex_d = '0;
        end else if (!EN_REG) begin
            id_ex_d = id_ex_q;
        end else if (stall_fetch) begin
            id_ex_d = '0;
        end else begin
            id_ex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign bus.stall_fetch = stall_fetch;
    assign bus.pc_out      = id_ex_q.pc;
    assign bus.op_a        = id_ex_q.op_a;
    assign bus.op_b        = id_ex_q.op_b;
    assign bus.imm         = id_ex_q.imm;
    assign bus.rd_out      = id_ex_q.rd;
    assign bus.alu_op      = id_ex_q.alu_op;
    assign bus.use_imm     = id_ex_q.use_imm;
    assign bus.reg_write   = id_ex_q.reg_write;
    assign bus.mem_read    = id_ex_q.mem_read;
    assign bus.mem_write   = id_ex_q.mem_write;
    assign bus.mem_byte    = id_ex_q.mem_byte;
    assign bus.branch      = id_ex_q.branch;
    assign bus.jump        = id_ex_q.jump;
    assign bus.illegal     = id_ex_q.illegal;

endmodule
